// File: rtl/cla_4bit.sv
// cla_4bit: 4-bit carry-lookahead add/subtract unit with optional signed
// saturation, group propagate/generate for cascading, and a registered copy
// of the result flags.
module cla_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    input  logic       sat,
    output logic [3:0] sum,
    output logic       cout,
    output logic       ovfl,
    output logic       pg,
    output logic       gg,
    output logic [3:0] sum_q,
    output logic       cout_q,
    output logic       ovfl_q
);

    logic [3:0] bx;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] raw;
    logic       c0, c1, c2, c3, c4;

    logic [3:0] sum_d;
    logic       cout_d;
    logic       ovfl_d;

    // Operand conditioning, per-bit terms and two-level lookahead carries
    always_comb begin
        bx = b ^ {4{sub}};
        c0 = cin ^ sub;
        g  = a & bx;
        p  = a ^ bx;

        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c0);

        raw = p ^ {c3, c2, c1, c0};
    end

    // Result flags, group terms and saturation clamp
    always_comb begin
        cout = c4;
        ovfl = (a[3] == bx[3]) && (raw[3] != a[3]);
        pg   = &p;
        // Same expression as c4 with the carry-in term dropped (c0 = 0)
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]);
        if (sat && ovfl) begin
            sum = a[3] ? 4'b1000 : 4'b0111;
        end else begin
            sum = raw;
        end
    end

    // Next-state for the output registers is the live combinational result
    always_comb begin
        sum_d  = sum;
        cout_d = cout;
        ovfl_d = ovfl;
    end

    // Output registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= 4'b0000;
            cout_q <= 1'b0;
            ovfl_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovfl_q <= ovfl_d;
        end
    end

endmodule

// File: tb/tb_cla_4bit.sv
// tb_cla_4bit: directed vectors, reset behaviour and an exhaustive sweep of
// cla_4bit against an integer arithmetic model via a scoreboard queue.
module tb_cla_4bit;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       ovfl;
        logic       pg;
        logic       gg;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       sub;
    logic       sat;
    logic [3:0] sum;
    logic       cout;
    logic       ovfl;
    logic       pg;
    logic       gg;
    logic [3:0] sum_q;
    logic       cout_q;
    logic       ovfl_q;

    int checks = 0;
    int errors = 0;

    exp_t comb_q[$];
    exp_t reg_q[$];

    cla_4bit dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sub    (sub),
        .sat    (sat),
        .sum    (sum),
        .cout   (cout),
        .ovfl   (ovfl),
        .pg     (pg),
        .gg     (gg),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovfl_q (ovfl_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Integer reference: signed result range decides overflow/clamp,
    // unsigned sum of the effective operands decides the carries.
    function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv,
                                   input logic ci, input logic sb, input logic st);
        exp_t e;
        int sa, sbv, ua, ub, ubx, c0, res, usum;
        logic [31:0] res_bits;
        sa  = $signed(av);
        sbv = $signed(bv);
        ua  = av;
        ub  = bv;
        c0  = (ci ^ sb) ? 1 : 0;
        res = sb ? (sa - sbv - (ci ? 1 : 0)) : (sa + sbv + (ci ? 1 : 0));
        ubx = sb ? (15 - ub) : ub;
        usum = ua + ubx + c0;
        res_bits = res;
        e.ovfl = (res > 7) || (res < -8);
        if (st && res > 7)       e.sum = 4'd7;
        else if (st && res < -8) e.sum = 4'd8;
        else                     e.sum = res_bits[3:0];
        e.cout = (usum > 15);
        e.gg   = ((ua + ubx) > 15);
        e.pg   = ((ua ^ ubx) == 15);
        return e;
    endfunction

    task automatic drive(input logic [3:0] av, input logic [3:0] bv,
                         input logic ci, input logic sb, input logic st);
        a   = av;
        b   = bv;
        cin = ci;
        sub = sb;
        sat = st;
    endtask

    initial begin
        exp_t e;
        exp_t got;
        logic [10:0] v;

        rst = 1'b1;
        drive(4'd3, 4'd2, 1'b0, 1'b0, 1'b0);

        // Reset held across edges
        repeat (2) @(negedge clk);
        chk("rst_sum_q", sum_q, 0);
        chk("rst_cout_q", cout_q, 0);
        chk("rst_ovfl_q", ovfl_q, 0);
        chk("rst_comb_sum", sum, 5);

        // Release and take one edge
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("load_sum_q", sum_q, 5);

        // Asynchronous clear between edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_clr_sum_q", sum_q, 0);
        chk("async_clr_comb", sum, 5);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        drive(4'd4, 4'd1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("add_sum", sum, 5);
        chk("add_ovfl", ovfl, 0);
        chk("add_cout", cout, 0);

        @(negedge clk);
        drive(4'b1110, 4'd5, 1'b0, 1'b1, 1'b1);
        #1;
        chk("sub_sum", sum, 4'b1001);
        chk("sub_ovfl", ovfl, 0);
        chk("sub_cout", cout, 1);

        @(negedge clk);
        drive(4'd7, 4'd1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("psat_sum", sum, 4'b0111);
        chk("psat_ovfl", ovfl, 1);
        sat = 1'b0;
        #1;
        chk("pwrap_sum", sum, 4'b1000);
        chk("pwrap_ovfl", ovfl, 1);

        @(negedge clk);
        drive(4'b1010, 4'b1001, 1'b0, 1'b0, 1'b1);
        #1;
        chk("nsat_sum", sum, 4'b1000);
        chk("nsat_ovfl", ovfl, 1);
        chk("nsat_cout", cout, 1);
        sat = 1'b0;
        #1;
        chk("nwrap_sum", sum, 4'b0011);

        // Exhaustive sweep with combinational and registered scoreboards
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            v = i[10:0];
            drive(v[3:0], v[7:4], v[8], v[9], v[10]);
            e = model(v[3:0], v[7:4], v[8], v[9], v[10]);
            comb_q.push_back(e);
            reg_q.push_back(e);
            #1;
            got = comb_q.pop_front();
            if ({sum, cout, ovfl, pg, gg} !== got) begin
                chk("sweep_sum", sum, got.sum);
                chk("sweep_cout", cout, got.cout);
                chk("sweep_ovfl", ovfl, got.ovfl);
                chk("sweep_pg", pg, got.pg);
                chk("sweep_gg", gg, got.gg);
            end else begin
                chk("sweep_comb", {sum, cout, ovfl, pg, gg}, got);
            end
            @(posedge clk);
            #1;
            got = reg_q.pop_front();
            chk("sweep_reg", {sum_q, cout_q, ovfl_q}, {got.sum, got.cout, got.ovfl});
        end

        chk("queues_empty", comb_q.size() + reg_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_4bit.md
CLA_4BIT -- requirements
Module: cla_4bit

Interface
REQ-001 clk  input  1  clock; rising edge updates the registered outputs only.
REQ-002 rst  input  1  reset; asynchronous, active-high; clears the registered outputs.
REQ-003 a  input  4  operand A, two's complement.
REQ-004 b  input  4  operand B, two's complement.
REQ-005 cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-006 sub  input  1  operation select: 0 = add, 1 = subtract.
REQ-007 sat  input  1  saturation enable: 1 = clamp on signed overflow, 0 = wrap.
REQ-008 sum  output  4  combinational result.
REQ-009 cout  output  1  combinational raw carry out of bit 3.
REQ-010 ovfl  output  1  combinational signed-overflow flag.
REQ-011 pg  output  1  group propagate, for cascading.
REQ-012 gg  output  1  group generate, for cascading.
REQ-013 sum_q  output  4  registered copy of sum.
REQ-014 cout_q  output  1  registered copy of cout.
REQ-015 ovfl_q  output  1  registered copy of ovfl.

Function
REQ-016 Effective B operand: bx = b XOR {4{sub}}.
REQ-017 Carry-in to bit 0: c0 = cin XOR sub.
  - sub=0: result = a + b + cin.
  - sub=1: result = a - b - cin.
REQ-018 Per-bit terms, i = 0..3: gi = a[i] AND bx[i]; pi = a[i] XOR bx[i].
REQ-019 All carries SHALL use lookahead form, with no ripple chain:
  - c1 = g0 | p0c0
  - c2 = g1 | p1g0 | p1p0c0
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
  - c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0
REQ-020 Raw sum: raw[i] = pi XOR ci.
REQ-021 cout = c4 always, independent of sat.
REQ-022 pg = p3 & p2 & p1 & p0.
REQ-023 gg = c4 evaluated with c0 = 0.
REQ-024 ovfl = (a[3] == bx[3]) AND (raw[3] != a[3]), independent of sat.
REQ-025 If sat=1 and ovfl=1:
  - sum = 4'b0111 when a[3]=0 (positive overflow).
  - sum = 4'b1000 when a[3]=1 (negative overflow).
REQ-026 If sat=0 or ovfl=0, sum = raw.
REQ-027 sum, cout, ovfl, pg and gg SHALL be purely combinational, valid within the same cycle as the inputs, zero latency.
REQ-028 On each rising clk edge with rst=0, the registered outputs SHALL capture the current combinational values: sum_q<=sum, cout_q<=cout, ovfl_q<=ovfl.
REQ-029 Registered outputs have latency of exactly one cycle.

Reset
REQ-030 While rst=1, sum_q=0, cout_q=0 and ovfl_q=0, asynchronously, regardless of clk.
REQ-031 Combinational outputs are unaffected by rst.
REQ-032 On rst deassertion, the first rising edge loads the current combinational values.
REQ-033 Reset asserted mid-operation SHALL clear the registers immediately, without waiting for a clock edge.

Verification
REQ-034 Add: a=4, b=1, cin=0, sub=0, sat=1 -> sum=5, ovfl=0, cout=0.
REQ-035 Subtract: a=-2 (1110), b=5, cin=0, sub=1, sat=1 -> sum=-7 (1001), ovfl=0, cout=1.
REQ-036 Positive saturation: a=7, b=1, sub=0, cin=0, sat=1 -> sum=0111, ovfl=1.
  - Same inputs with sat=0 -> sum=1000.
REQ-037 Negative saturation: a=-6 (1010), b=-7 (1001), sub=0, cin=0, sat=1 -> sum=1000, ovfl=1, cout=1.
  - Same inputs with sat=0 -> sum=0011.
REQ-038 Exhaustive sweep: all a, b, cin, sub, sat combinations (2048) -> sum, cout and ovfl match a behavioural model.
  - Also check pg=&(a^bx) and gg.
REQ-039 Registers: hold rst=1 -> sum_q=0, cout_q=0, ovfl_q=0.
  - Release rst with a=3, b=2, sub=0, cin=0, then apply one clk edge -> sum_q=5.
  - Assert rst between edges -> sum_q clears to 0 immediately.
